decode_issue_ctrl: RTL
======================

# decode_issue_ctrl

ID-stage controller for the 5-stage RV64 pipeline. Accepts fetched instructions from IF over a valid/ready handshake and buffers them in a 2-entry skid queue. Each entry is tagged at enqueue with its 64-bit sign-extended immediate and register indices. Entries issue to EX in order, with load-use hazard stalling and redirect flush.

## Interface
- XLEN, 64, datapath/PC width
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_valid  in  1  IF presents an instruction
- if_ready  out  1  controller can accept; decoded from registered occupancy only
- if_instr  in  32  raw instruction
- if_pc  in  XLEN  instruction PC
- flush  in  1  branch/jump redirect from EX; discards all buffered entries
- ex_ld_valid  in  1  EX stage holds a load
- ex_ld_rd  in  5  destination of that load
- id_valid  out  1  head entry issuable this cycle
- id_ready  in  1  EX accepts
- id_pc  out  XLEN  head PC
- id_instr  out  32  head instruction
- id_imm  out  XLEN  head immediate
- id_rs1, id_rs2, id_rd  out  5 each  head register indices (instr[19:15], [24:20], [11:7])
- id_stall  out  1  head valid but blocked by load-use hazard

## Operation
- enq = if_valid & if_ready; deq = id_valid & id_ready.
- Occupancy FSM with states EMPTY, ONE, TWO:
  - EMPTY: enq → ONE.
  - ONE: enq & ~deq → TWO; deq & ~enq → EMPTY; otherwise stays ONE.
  - TWO: deq → ONE. enq is impossible because if_ready = 0.
  - flush → EMPTY from any state. flush has priority over enq and deq in the same cycle, and any concurrent IF transfer is dropped.
- if_ready = (state != TWO).
- Entry contents: {pc, instr, imm}. The immediate is computed combinationally from if_instr and stored at enqueue, so id_imm is a registered output.
- Head is always the oldest entry. On deq with TWO, the second entry moves to head.
- Immediate rules by opcode:
  - I-type (LOAD, OP-IMM, OP-IMM-32, JALR), S, B, U, J: standard RV formats, sign-extended to XLEN.
  - Unknown opcodes: 0.
- Source usage by opcode:
  - rs1 used by LOAD, OP-IMM, OP-IMM-32, JALR, STORE, BRANCH, OP, OP-32.
  - rs2 used by STORE, BRANCH, OP, OP-32.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
- hazard = head valid & ex_ld_valid & (ex_ld_rd != 0) & ((rs1 used & rs1 == ex_ld_rd) | (rs2 used & rs2 == ex_ld_rd)).
- id_valid = head valid & ~hazard; id_stall = head valid & hazard.
- While stalled, the head holds; IF may still fill the second slot.

## Timing
- Reset values (asserted immediately, asynchronously): state EMPTY, id_valid 0, id_stall 0, all data outputs 0, if_ready 1. No enq occurs while rst is high.
- Latency: an enq at edge N makes the entry visible on id_* and id_valid after edge N, i.e. in cycle N+1 (1 cycle).
- Throughput: 1 instruction/cycle when id_ready is held high.
- if_ready deasserts the cycle after occupancy reaches TWO and reasserts the cycle after a deq or flush.
- Stall path: hazard, id_valid and id_stall are combinational from ex_ld_* and head registers. There is no combinational path from if_* to id_*.
- flush at edge N: id_valid = 0 in cycle N+1 and if_ready = 1.
- Reset asserted mid-stream discards all entries. The first enq after release is accepted on the first edge with rst low.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OP32, OPC_LUI, OPC_AUIPC, OPC_JAL);
  - occupancy enum occ_e {EMPTY, ONE, TWO};
  - id_entry_t struct {pc, instr, imm}.
- The existing imm_extractor is instantiated once as a sub-module on if_instr. Its output is the stored imm.
- Source-usage decode is a local function in this block.

## Test plan
- Pass-through: ADDI x1,x2,-1 (0xFFF10093) with id_ready=1 → next cycle id_valid=1, id_imm=0xFFFFFFFFFFFFFFFF, rs1=2, rd=1, id_stall=0.
- Backpressure: id_ready=0 for 3 cycles while IF offers I0..I2 → I0 and I1 accepted, if_ready=0 from the cycle after I1. Then id_ready=1 → I0, I1, I2 issue in order with no loss or duplication.
- Load-use: head ADD x3,x5,x6 (0x006281B3) with ex_ld_valid=1, ex_ld_rd=5 → id_valid=0, id_stall=1 while held. Drop ex_ld_valid → issues in the same cycle. The same test with ex_ld_rd=0, or head LUI x5, gives no stall.
- Flush: state TWO plus flush together with if_valid=1 → next cycle id_valid=0, if_ready=1, and the offered instruction is never issued.
- Immediates: SW (S-type), BEQ offset -4, AUIPC 0x80000, JAL offset +2048 → sign-extended values match the RV spec exactly. Opcode 0x7F → imm 0.
- Async reset asserted mid-stream in state TWO, between clock edges → outputs go to reset values without waiting for a clock edge. First instruction after release issues with 1-cycle latency.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 decode definitions: major opcodes, ID-queue occupancy and entry layout.
package riscv_pkg;

   localparam int XLEN = 64;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [XLEN-1:0] imm;
   } id_entry_t;

endpackage

// File: rtl/imm_extractor.sv
// Combinational RV64 immediate generator; formats without an immediate yield zero.
module imm_extractor
   import riscv_pkg::*;
(
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] imm_o
);

   logic [6:0] opc;
   logic       sgn;

   assign opc = instr_i[6:0];
   assign sgn = instr_i[31];

   always_comb begin
      imm_o = '0;
      case (opc)
         OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR:
            imm_o = {{52{sgn}}, instr_i[31:20]};
         OPC_STORE:
            imm_o = {{52{sgn}}, instr_i[31:25], instr_i[11:7]};
         OPC_BRANCH:
            imm_o = {{51{sgn}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm_o = {{32{sgn}}, instr_i[31:12], 12'b0};
         OPC_JAL:
            imm_o = {{43{sgn}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
         default:
            imm_o = '0;
      endcase
   end

endmodule

// File: rtl/decode_issue_ctrl.sv
// ID-stage controller: 2-entry in-order skid queue between IF and EX with
// load-use stall and redirect flush.
module decode_issue_ctrl
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush,
   input  logic            ex_ld_valid,
   input  logic [4:0]      ex_ld_rd,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_imm,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [4:0]      id_rd,
   output logic            id_stall
);

   occ_e      state_q, state_d;
   id_entry_t head_q, head_d;
   id_entry_t tail_q, tail_d;
   id_entry_t new_entry;
   logic [XLEN-1:0] new_imm;

   logic enq, deq;
   logic head_valid, hazard;
   logic rs1_used, rs2_used;

   // Returns {rs2_used, rs1_used} for a major opcode.
   function automatic logic [1:0] src_use(input logic [6:0] opc);
      logic [1:0] u;
      u = 2'b00;
      case (opc)
         OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR: u = 2'b01;
         OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OP32:      u = 2'b11;
         default:                                      u = 2'b00;
      endcase
      return u;
   endfunction

   imm_extractor u_imm (
      .instr_i (if_instr),
      .imm_o   (new_imm)
   );

   assign new_entry = '{pc: if_pc, instr: if_instr, imm: new_imm};

   assign if_ready   = (state_q != TWO);
   assign head_valid = (state_q != EMPTY);

   assign id_pc    = head_q.pc;
   assign id_instr = head_q.instr;
   assign id_imm   = head_q.imm;
   assign id_rs1   = head_q.instr[19:15];
   assign id_rs2   = head_q.instr[24:20];
   assign id_rd    = head_q.instr[11:7];

   assign {rs2_used, rs1_used} = src_use(head_q.instr[6:0]);

   // Only the registered head feeds the hazard check, so IF never reaches id_* combinationally.
   assign hazard = head_valid & ex_ld_valid & (ex_ld_rd != 5'd0) &
                   ((rs1_used & (id_rs1 == ex_ld_rd)) | (rs2_used & (id_rs2 == ex_ld_rd)));

   assign id_valid = head_valid & ~hazard;
   assign id_stall = head_valid & hazard;

   assign enq = if_valid & if_ready;
   assign deq = id_valid & id_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (enq) begin
                  head_d  = new_entry;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (enq && deq) begin
                  head_d = new_entry;
               end else if (enq) begin
                  tail_d  = new_entry;
                  state_d = TWO;
               end else if (deq) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (deq) begin
                  head_d  = tail_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule
